// File: rtl/fibo_bcd_converter_if.sv
// Handshake bundle between a requester and the binary-to-BCD converter.
// The master drives start/bin_in and the slave returns status and result.
interface fibo_bcd_converter_if;
    logic        start;
    logic [15:0] bin_in;
    logic        busy;
    logic        done;
    logic [19:0] bcd_out;
    logic [2:0]  ndigits;

    modport master (
        output start, bin_in,
        input  busy, done, bcd_out, ndigits
    );

    modport slave (
        input  start, bin_in,
        output busy, done, bcd_out, ndigits
    );
endinterface

// File: rtl/fibo_bcd_converter.sv
// 16-bit binary to 5-digit packed BCD converter (shift-and-add-3).
// Sixteen shift cycles per conversion, then a one-cycle done pulse.
module fibo_bcd_converter (
    input logic                clk,
    input logic                reset_n,
    fibo_bcd_converter_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]  r_state;
    logic [15:0] r_sr;
    logic [19:0] r_acc;
    logic [4:0]  r_cnt;
    logic [19:0] r_bcd;
    logic [2:0]  r_nd;

    logic [19:0] w_corr;
    logic [35:0] w_shift;
    logic [19:0] w_acc_nx;
    logic [2:0]  w_nd;

    always_comb begin
        w_corr = r_acc;
        for (int i = 0; i < 5; i++) begin
            if (r_acc[4*i +: 4] >= 4'd5) begin
                w_corr[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
            end
        end
    end

    assign w_shift  = {w_corr, r_sr} << 1;
    assign w_acc_nx = w_shift[35:16];

    // Significant-digit count of the value being loaded; zero counts as one digit.
    always_comb begin
        w_nd = 3'd1;
        if (w_acc_nx[19:16] != 4'd0) begin
            w_nd = 3'd5;
        end else if (w_acc_nx[15:12] != 4'd0) begin
            w_nd = 3'd4;
        end else if (w_acc_nx[11:8] != 4'd0) begin
            w_nd = 3'd3;
        end else if (w_acc_nx[7:4] != 4'd0) begin
            w_nd = 3'd2;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_sr    <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_bcd   <= '0;
            r_nd    <= 3'd1;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_sr    <= bus.bin_in;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_sr  <= w_shift[15:0];
                    r_acc <= w_acc_nx;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd15) begin
                        r_bcd   <= w_acc_nx;
                        r_nd    <= w_nd;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = (r_state == S_SHIFT);
    assign bus.done    = (r_state == S_DONE);
    assign bus.bcd_out = r_bcd;
    assign bus.ndigits = r_nd;
endmodule
